// File: rtl/carrier_envelope_detect.sv
// carrier_envelope_detect: qualifies the raw 13.5 MHz receive-comparator output
// into a clean burst envelope. A burst is accepted only after several carrier
// periods of the right length. The block also reports how many carrier rises the
// last accepted burst held, and how many candidate bursts were abandoned.
module carrier_envelope_detect #(
  parameter int CLK_FREQ        = 81_000_000,
  parameter int MODULATION_FREQ = 13_500_000,
  parameter int PERIOD_TOL      = 1,
  parameter int QUALIFY_CYCLES  = 3,
  parameter int TIMEOUT_CYCLES  = 12,
  parameter int HOLDOFF_CYCLES  = 24,
  parameter int CNT_WIDTH       = 8
) (
  input  logic                 clk,
  input  logic                 n_reset,
  input  logic                 rx_in,
  output logic                 env_out,
  output logic                 burst_done,
  output logic [CNT_WIDTH-1:0] burst_cycles,
  output logic [CNT_WIDTH-1:0] reject_count
);

  localparam int NOMINAL = CLK_FREQ / MODULATION_FREQ;
  localparam int PER_MAX = (TIMEOUT_CYCLES > HOLDOFF_CYCLES) ? TIMEOUT_CYCLES : HOLDOFF_CYCLES;
  localparam int PER_W   = $clog2(PER_MAX + 2);
  localparam int GOOD_W  = $clog2(QUALIFY_CYCLES + 1);

  localparam logic [PER_W-1:0]  P_MIN     = (NOMINAL > PERIOD_TOL) ? PER_W'(NOMINAL - PERIOD_TOL) : PER_W'(0);
  localparam logic [PER_W-1:0]  P_MAX     = PER_W'(NOMINAL + PERIOD_TOL);
  localparam logic [PER_W-1:0]  TMO       = PER_W'(TIMEOUT_CYCLES);
  localparam logic [PER_W-1:0]  HOLD      = PER_W'(HOLDOFF_CYCLES);
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(QUALIFY_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, QUALIFY, ACTIVE, HOLDOFF} state_e;

  state_e                 state_q, state_d;
  logic                   rx_meta_q, rx_meta_d;
  logic                   rx_sync_q, rx_sync_d;
  logic                   rx_prev_q, rx_prev_d;
  logic [PER_W-1:0]       per_ctr_q, per_ctr_d;
  logic [GOOD_W-1:0]      good_cnt_q, good_cnt_d;
  logic [CNT_WIDTH-1:0]   run_cnt_q, run_cnt_d;
  logic                   env_out_q, env_out_d;
  logic                   burst_done_q, burst_done_d;
  logic [CNT_WIDTH-1:0]   burst_cycles_q, burst_cycles_d;
  logic [CNT_WIDTH-1:0]   reject_count_q, reject_count_d;

  logic rise;
  logic period_ok;
  logic timeout;
  logic holdoff_end;

  function automatic logic [PER_W-1:0] per_inc(input logic [PER_W-1:0] v);
    return (&v) ? v : v + PER_W'(1);
  endfunction

  function automatic logic [CNT_WIDTH-1:0] cnt_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  // Next-state logic: synchroniser shift, period measurement and burst FSM.
  always_comb begin
    rx_meta_d      = rx_in;
    rx_sync_d      = rx_meta_q;
    rx_prev_d      = rx_sync_q;

    rise        = rx_sync_q & ~rx_prev_q;
    period_ok   = (per_ctr_q >= P_MIN) && (per_ctr_q <= P_MAX);
    timeout     = (per_ctr_q == TMO);
    holdoff_end = (per_ctr_q == HOLD);

    state_d        = state_q;
    per_ctr_d      = per_inc(per_ctr_q);
    good_cnt_d     = good_cnt_q;
    run_cnt_d      = run_cnt_q;
    burst_done_d   = 1'b0;
    burst_cycles_d = burst_cycles_q;
    reject_count_d = reject_count_q;

    unique case (state_q)
      IDLE: begin
        if (rise) begin
          state_d    = QUALIFY;
          per_ctr_d  = PER_W'(1);
          good_cnt_d = '0;
          run_cnt_d  = CNT_WIDTH'(1);
        end
      end
      QUALIFY: begin
        // A rise always wins over a coincident timeout.
        if (rise) begin
          per_ctr_d = PER_W'(1);
          if (period_ok) begin
            good_cnt_d = good_cnt_q + GOOD_W'(1);
            run_cnt_d  = cnt_inc(run_cnt_q);
            if (good_cnt_q == GOOD_LAST) state_d = ACTIVE;
          end else begin
            good_cnt_d = '0;
            run_cnt_d  = CNT_WIDTH'(1);
          end
        end else if (timeout) begin
          state_d        = IDLE;
          reject_count_d = cnt_inc(reject_count_q);
        end
      end
      ACTIVE: begin
        // Off-length periods are tolerated once the burst is accepted.
        if (rise) begin
          per_ctr_d = PER_W'(1);
          run_cnt_d = cnt_inc(run_cnt_q);
        end else if (timeout) begin
          state_d        = HOLDOFF;
          per_ctr_d      = PER_W'(1);
          burst_done_d   = 1'b1;
          burst_cycles_d = run_cnt_q;
        end
      end
      HOLDOFF: begin
        // Echoes and ringing after a burst are ignored entirely.
        if (holdoff_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    env_out_d = (state_d == ACTIVE);
  end

  // State and output registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q        <= IDLE;
      rx_meta_q      <= 1'b0;
      rx_sync_q      <= 1'b0;
      rx_prev_q      <= 1'b0;
      per_ctr_q      <= '0;
      good_cnt_q     <= '0;
      run_cnt_q      <= '0;
      env_out_q      <= 1'b0;
      burst_done_q   <= 1'b0;
      burst_cycles_q <= '0;
      reject_count_q <= '0;
    end else begin
      state_q        <= state_d;
      rx_meta_q      <= rx_meta_d;
      rx_sync_q      <= rx_sync_d;
      rx_prev_q      <= rx_prev_d;
      per_ctr_q      <= per_ctr_d;
      good_cnt_q     <= good_cnt_d;
      run_cnt_q      <= run_cnt_d;
      env_out_q      <= env_out_d;
      burst_done_q   <= burst_done_d;
      burst_cycles_q <= burst_cycles_d;
      reject_count_q <= reject_count_d;
    end
  end

  assign env_out      = env_out_q;
  assign burst_done   = burst_done_q;
  assign burst_cycles = burst_cycles_q;
  assign reject_count = reject_count_q;

endmodule

// File: tb/tb_carrier_envelope_detect.sv
// Testbench for carrier_envelope_detect. Expected burst_cycles values are queued
// when a burst is driven and checked by a monitor whenever burst_done fires.
// Edge times: cyc counts rising edges; a value driven while cyc==c is first
// sampled on edge c+1.
module tb_carrier_envelope_detect;

  logic       clk = 1'b0;
  logic       n_reset = 1'b0;
  logic       rx_in = 1'b0;
  logic       env_out;
  logic       burst_done;
  logic [7:0] burst_cycles;
  logic [7:0] reject_count;

  carrier_envelope_detect dut (
    .clk          (clk),
    .n_reset      (n_reset),
    .rx_in        (rx_in),
    .env_out      (env_out),
    .burst_done   (burst_done),
    .burst_cycles (burst_cycles),
    .reject_count (reject_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  int exp_q[$];
  int env_rises, env_falls, env_rise_cyc, env_fall_cyc;
  int done_cnt, done_cyc;
  logic env_prev = 1'b0;
  int last_rise;

  // Monitor: envelope edges and scoreboard check on each burst_done.
  always @(negedge clk) begin
    if (env_out === 1'b1 && env_prev !== 1'b1) begin
      env_rises++;
      env_rise_cyc = cyc;
    end
    if (env_out !== 1'b1 && env_prev === 1'b1) begin
      env_falls++;
      env_fall_cyc = cyc;
    end
    env_prev = env_out;
    if (burst_done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_burst_done: burst_cycles=%0d at cyc %0d, none expected", burst_cycles, cyc);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (burst_cycles !== 8'(e)) begin
          errors++;
          $display("FAIL burst_cycles: got %0d expected %0d", burst_cycles, e);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clear_stats();
    env_rises = 0; env_falls = 0; env_rise_cyc = -1; env_fall_cyc = -1;
    done_cnt = 0; done_cyc = -1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    n_reset = 1'b0;
    rx_in   = 1'b0;
    @(negedge clk);
    n_reset = 1'b1;
    @(negedge clk);
    #1;
    clear_stats();
  endtask

  // n periods of the given length, each starting with a rising edge, 50% duty.
  task automatic pulse_train(input int n, input int gap);
    for (int k = 0; k < n; k++) begin
      last_rise = cyc + 1;
      for (int i = 0; i < gap; i++) begin
        rx_in = (i < gap / 2);
        @(negedge clk);
      end
    end
  endtask

  task automatic idle(input int n);
    rx_in = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Hold rx_in low so that the next driven value is first sampled on edge t.
  task automatic idle_until(input int t);
    rx_in = 1'b0;
    while (cyc < t - 1) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (env_out !== 1'b0) begin errors++; $display("FAIL reset_env: got %0d expected 0", env_out); end
    checks++; if (burst_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0d expected 0", burst_done); end
    checks++; if (burst_cycles !== 8'd0) begin errors++; $display("FAIL reset_burst_cycles: got %0d expected 0", burst_cycles); end
    checks++; if (reject_count !== 8'd0) begin errors++; $display("FAIL reset_reject: got %0d expected 0", reject_count); end
  endtask

  task automatic test_nominal_burst();
    int start;
    do_reset();
    exp_q.push_back(12);
    start = cyc + 1;
    pulse_train(12, 6);
    idle(30);
    // Edges counted with the first sampling edge as number 1: rise on edge 21,
    // fall on edge 15 counted from the last rise sample.
    checks++; if (env_rise_cyc - start + 1 !== 21) begin errors++; $display("FAIL nominal_env_rise: got %0d expected 21", env_rise_cyc - start + 1); end
    checks++; if (env_fall_cyc - last_rise + 1 !== 15) begin errors++; $display("FAIL nominal_env_fall: got %0d expected 15", env_fall_cyc - last_rise + 1); end
    checks++; if (env_rises !== 1) begin errors++; $display("FAIL nominal_env_rises: got %0d expected 1", env_rises); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL nominal_done_count: got %0d expected 1", done_cnt); end
    checks++; if (done_cyc !== env_fall_cyc) begin errors++; $display("FAIL nominal_done_time: got %0d expected %0d", done_cyc, env_fall_cyc); end
    checks++; if (reject_count !== 8'd0) begin errors++; $display("FAIL nominal_reject: got %0d expected 0", reject_count); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL nominal_scoreboard: got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_reject();
    do_reset();
    pulse_train(2, 6);
    idle(40);
    checks++; if (reject_count !== 8'd1) begin errors++; $display("FAIL reject_count: got %0d expected 1", reject_count); end
    checks++; if (env_rises !== 0) begin errors++; $display("FAIL reject_env: got %0d rises expected 0", env_rises); end
    checks++; if (done_cnt !== 0) begin errors++; $display("FAIL reject_done: got %0d expected 0", done_cnt); end
  endtask

  task automatic test_bad_period();
    int gaps[9] = '{6, 9, 6, 6, 6, 6, 9, 6, 6};
    int start, r5;
    do_reset();
    // Qualification restarts at the 9-clk period; 4 rises counted by the time
    // the burst is accepted, then 3 more while active.
    exp_q.push_back(7);
    start = cyc + 1;
    r5 = start;
    for (int i = 0; i < 5; i++) r5 += gaps[i];
    for (int i = 0; i < 9; i++) pulse_train(1, gaps[i]);
    idle(30);
    checks++; if (env_rise_cyc !== r5 + 2) begin errors++; $display("FAIL badper_env_rise: got %0d expected %0d", env_rise_cyc, r5 + 2); end
    checks++; if (env_rises !== 1 || env_falls !== 1) begin errors++; $display("FAIL badper_env_toggles: got %0d/%0d expected 1/1", env_rises, env_falls); end
    checks++; if (env_fall_cyc !== last_rise + 14) begin errors++; $display("FAIL badper_env_fall: got %0d expected %0d", env_fall_cyc, last_rise + 14); end
    checks++; if (reject_count !== 8'd0) begin errors++; $display("FAIL badper_reject: got %0d expected 0", reject_count); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL badper_scoreboard: got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_holdoff();
    int d, start2;
    do_reset();
    exp_q.push_back(12);
    pulse_train(12, 6);
    d = last_rise + 14;
    idle_until(d + 10);
    pulse_train(2, 6);
    idle(40);
    checks++; if (done_cyc !== d) begin errors++; $display("FAIL holdoff_done_time: got %0d expected %0d", done_cyc, d); end
    checks++; if (env_rises !== 1) begin errors++; $display("FAIL holdoff_ignored_env: got %0d rises expected 1", env_rises); end
    checks++; if (reject_count !== 8'd0) begin errors++; $display("FAIL holdoff_reject: got %0d expected 0", reject_count); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL holdoff_done_count: got %0d expected 1", done_cnt); end

    do_reset();
    exp_q.push_back(12);
    exp_q.push_back(12);
    pulse_train(12, 6);
    d = last_rise + 14;
    idle_until(d + 30);
    start2 = cyc + 1;
    pulse_train(12, 6);
    idle(30);
    checks++; if (env_rise_cyc !== start2 + 20) begin errors++; $display("FAIL after_holdoff_env_rise: got %0d expected %0d", env_rise_cyc, start2 + 20); end
    checks++; if (done_cnt !== 2) begin errors++; $display("FAIL after_holdoff_done_count: got %0d expected 2", done_cnt); end
    checks++; if (reject_count !== 8'd0) begin errors++; $display("FAIL after_holdoff_reject: got %0d expected 0", reject_count); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL holdoff_scoreboard: got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_reset_active();
    do_reset();
    pulse_train(6, 6);
    checks++; if (env_out !== 1'b1) begin errors++; $display("FAIL rstact_env_before: got %0d expected 1", env_out); end
    n_reset = 1'b0;
    rx_in   = 1'b0;
    @(negedge clk);
    checks++; if (env_out !== 1'b0) begin errors++; $display("FAIL rstact_env: got %0d expected 0", env_out); end
    checks++; if (burst_done !== 1'b0) begin errors++; $display("FAIL rstact_done: got %0d expected 0", burst_done); end
    checks++; if (burst_cycles !== 8'd0) begin errors++; $display("FAIL rstact_burst_cycles: got %0d expected 0", burst_cycles); end
    checks++; if (reject_count !== 8'd0) begin errors++; $display("FAIL rstact_reject: got %0d expected 0", reject_count); end
    n_reset = 1'b1;
    idle(40);
    checks++; if (done_cnt !== 0) begin errors++; $display("FAIL rstact_no_done: got %0d expected 0", done_cnt); end
    checks++; if (reject_count !== 8'd0) begin errors++; $display("FAIL rstact_idle_reject: got %0d expected 0", reject_count); end
    checks++; if (env_out !== 1'b0) begin errors++; $display("FAIL rstact_env_after: got %0d expected 0", env_out); end
  endtask

  task automatic test_saturation();
    do_reset();
    exp_q.push_back(255);
    pulse_train(300, 6);
    idle(30);
    checks++; if (env_rises !== 1 || env_falls !== 1) begin errors++; $display("FAIL sat_env_toggles: got %0d/%0d expected 1/1", env_rises, env_falls); end
    checks++; if (env_fall_cyc !== last_rise + 14) begin errors++; $display("FAIL sat_env_fall: got %0d expected %0d", env_fall_cyc, last_rise + 14); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL sat_done_count: got %0d expected 1", done_cnt); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL sat_scoreboard: got %0d pending expected 0", exp_q.size()); end
  endtask

  initial begin
    clear_stats();
    test_reset();
    test_nominal_burst();
    test_reject();
    test_bad_period();
    test_holdoff();
    test_reset_active();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/carrier_envelope_detect.md
Name: carrier_envelope_detect

Overview:
Front-end qualifier that sits directly upstream of the delay line top level. It takes the raw comparator output of the 13.5 MHz modulated receive transducer and produces a clean, glitch-free pulse envelope, which drives the delay line's `in`. Bursts are accepted only after several carrier periods of correct length, so noise spikes never enter the FIFO. It also reports per-burst carrier count and a reject counter for bring-up.

Parameters:
CLK_FREQ, 81_000_000, system clock in Hz; must be an integer multiple of MODULATION_FREQ.
MODULATION_FREQ, 13_500_000, carrier frequency in Hz; NOMINAL = CLK_FREQ/MODULATION_FREQ (6 at defaults).
PERIOD_TOL, 1, allowed deviation in clocks of a measured carrier period from NOMINAL.
QUALIFY_CYCLES, 3, consecutive valid periods needed before the envelope asserts.
TIMEOUT_CYCLES, 12, clocks without a carrier rise that end a burst (must be > NOMINAL+PERIOD_TOL).
HOLDOFF_CYCLES, 24, dead time after burst end during which input is ignored.
CNT_WIDTH, 8, width of burst_cycles and reject_count.

Ports:
clk  in  1  system clock
n_reset  in  1  synchronous, active-low reset
rx_in  in  1  raw asynchronous carrier comparator output
env_out  out  1  qualified envelope, registered
burst_done  out  1  one-cycle strobe at end of each accepted burst
burst_cycles  out  CNT_WIDTH  carrier rises in last accepted burst, saturating
reject_count  out  CNT_WIDTH  abandoned candidate bursts, saturating

Behaviour:
- Reset behaviour:
  - One clock; reset is synchronous and active-low (n_reset sampled on posedge clk).
  - On reset, all registers clear: sync FFs, state=IDLE, env_out=0, burst_done=0, burst_cycles=0, reject_count=0, per_ctr=0, good_cnt=0.
  - Reset mid-burst takes effect at the next edge, with no burst_done and no reject increment.
- Input path:
  - 2-FF synchroniser produces rx_sync, followed by rx_prev.
  - rise = rx_sync & ~rx_prev.
  - Latency from rx_in first sampled high to a state/output update is 3 clock edges.
- Period counter (per_ctr):
  - Increments each clock and saturates at all-ones; width is clog2(max(TIMEOUT_CYCLES,HOLDOFF_CYCLES)+2).
  - On a rise, the measured period P = per_ctr and per_ctr loads 1.
  - A period is valid iff NOMINAL-PERIOD_TOL <= P <= NOMINAL+PERIOD_TOL (5..7 at defaults).
- State machine (IDLE, QUALIFY, ACTIVE, HOLDOFF):
  - IDLE: on rise -> QUALIFY; good_cnt=0, run_cnt=1.
  - QUALIFY:
    - Rise with valid P: good_cnt++, run_cnt++. When good_cnt reaches QUALIFY_CYCLES -> ACTIVE, and env_out goes 1 on the same edge.
    - Rise with invalid P: good_cnt=0, run_cnt=1, stay in QUALIFY, no reject.
    - per_ctr==TIMEOUT_CYCLES with no rise: -> IDLE, reject_count++.
  - ACTIVE:
    - Every rise: run_cnt++ (saturating); invalid periods are tolerated.
    - per_ctr==TIMEOUT_CYCLES with no rise: -> HOLDOFF. On that edge env_out=0, burst_done=1 for one cycle, and burst_cycles=run_cnt.
  - HOLDOFF: rises are ignored; per_ctr restarts at 1 on entry; when per_ctr==HOLDOFF_CYCLES -> IDLE.
- Simultaneous events: a rise in the same cycle per_ctr equals the timeout wins, so no timeout is taken.
- env_out equals (state==ACTIVE), registered, and never toggles inside a burst.
- Envelope timing at defaults:
  - Leading edge lags the first carrier rise by QUALIFY_CYCLES*NOMINAL+3 clocks.
  - Trailing edge lags the last carrier rise by TIMEOUT_CYCLES+3 clocks.
  - The top level compensates for both in DELAY_CYCLES.
- Counters saturate at 2^CNT_WIDTH-1 and never wrap.

Test Plan:
- Defaults; 12-rise burst, 6-clk period, 50% duty. Required: env_out rises 21 clks after the first rx_in high sample and falls 15 clks after the last rise sample. burst_done pulses once; burst_cycles=12; reject_count=0.
- 2-rise burst, then silence. Required: env_out stays 0; reject_count=1; burst_done never asserts.
- Periods 6,9,6,6,6. Required: the 9-clk period resets qualification, and env_out asserts on the 3rd valid period after it. Once ACTIVE, a single 9-clk period does not drop env_out.
- Second burst starting 10 clks after burst_done. Required: rises during HOLDOFF are ignored, no reject. A burst starting 30 clks after burst_done qualifies normally.
- n_reset low for 1 cycle while ACTIVE. Required: next edge env_out=0, all counters 0, state IDLE, and no burst_done.
- Continuous 300-rise carrier. Required: burst_cycles=255 after the end; env_out high throughout.
